// File: rtl/sync_fifo_v2_pkg.sv
// Shared definitions for the sync_fifo_v2 slice: width helper and default sizing.
package sync_fifo_v2_pkg;

  localparam int unsigned DEF_DATA_W   = 8;
  localparam int unsigned DEF_DEPTH    = 1024;
  localparam int unsigned DEF_AE_LEVEL = 2;

  // Ceiling log2; DEPTH >= 2 means callers always receive at least 1.
  function automatic int unsigned clogb2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(v)) r++;
    return r;
  endfunction

endpackage

// File: rtl/fifo_ram_sdp.sv
// Simple dual-port RAM: one write port, one registered read port with read enable.
module fifo_ram_sdp
  import sync_fifo_v2_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned DEPTH  = DEF_DEPTH,
  localparam int unsigned ADDR_W = clogb2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  // No reset on the array or read register so the block maps onto BRAM.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata_q <= mem[raddr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/sync_fifo_v2.sv
// Single-clock FIFO, any DEPTH >= 2, count-based flags and sticky error flags.
// Define SYNC_FIFO_FWFT_EN for first-word-fall-through output; otherwise standard read.
module sync_fifo_v2
  import sync_fifo_v2_pkg::*;
#(
  parameter int unsigned DATA_W   = DEF_DATA_W,
  parameter int unsigned DEPTH    = DEF_DEPTH,
  parameter int unsigned AF_LEVEL = DEPTH - 2,
  parameter int unsigned AE_LEVEL = DEF_AE_LEVEL,
  localparam int unsigned CNT_W   = clogb2(DEPTH + 1),
  localparam int unsigned PTR_W   = clogb2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] din,
  input  logic              rd_en,
  output logic [DATA_W-1:0] dout,
  output logic              dout_valid,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic [CNT_W-1:0]  data_count,
  output logic              overflow,
  output logic              underflow
);

  localparam logic [PTR_W-1:0] PTR_LAST  = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] AF_CNT    = CNT_W'(AF_LEVEL);
  localparam logic [CNT_W-1:0] AE_CNT    = CNT_W'(AE_LEVEL);

  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [DATA_W-1:0] dout_q, dout_d, ram_rdata;
  logic              full_q, full_d, empty_q, empty_d;
  logic              af_q, af_d, ae_q, ae_d;
  logic              ovf_q, ovf_d, unf_q, unf_d;
  logic              pend_q, pend_d, dvld_q, dvld_d;
  logic              go, wr_acc, rd_acc, ram_re, out_load;
`ifdef SYNC_FIFO_FWFT_EN
  logic [CNT_W-1:0]  inflight;
`endif

  // Wrap by compare so non-power-of-two depths use every RAM word.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
  endfunction

  always_comb begin
    go     = rst_n && !clr;
    wr_acc = go && wr_en && !full_q;
    rd_acc = go && rd_en && !empty_q;
`ifdef SYNC_FIFO_FWFT_EN
    // Words already pulled out of the array: one in the RAM read register, one on dout.
    inflight = CNT_W'(pend_q) + CNT_W'(dvld_q);
    out_load = pend_q && (!dvld_q || rd_acc);
    ram_re   = go && (count_q > inflight) && (!pend_q || out_load);
    dvld_d   = out_load || (dvld_q && !rd_acc);
`else
    out_load = pend_q;
    ram_re   = rd_acc;
    dvld_d   = out_load;
`endif
    pend_d   = ram_re || (pend_q && !out_load);
    dout_d   = out_load ? ram_rdata : dout_q;
    wr_ptr_d = wr_acc ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = ram_re ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    ovf_d = ovf_q || (wr_en && full_q);
    unf_d = unf_q || (rd_en && empty_q);

    if (clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      pend_d   = 1'b0;
      dvld_d   = 1'b0;
      dout_d   = '0;
      ovf_d    = 1'b0;
      unf_d    = 1'b0;
    end

    full_d = (count_d == DEPTH_CNT);
    af_d   = (count_d >= AF_CNT);
    ae_d   = (count_d <= AE_CNT);
`ifdef SYNC_FIFO_FWFT_EN
    empty_d = !dvld_d;
`else
    empty_d = (count_d == '0);
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      dout_q   <= '0;
      pend_q   <= 1'b0;
      dvld_q   <= 1'b0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      af_q     <= (AF_LEVEL == 0);
      ae_q     <= 1'b1;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      dout_q   <= dout_d;
      pend_q   <= pend_d;
      dvld_q   <= dvld_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      af_q     <= af_d;
      ae_q     <= ae_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  fifo_ram_sdp #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_ram (
    .clk   (clk),
    .we    (wr_acc),
    .waddr (wr_ptr_q),
    .wdata (din),
    .re    (ram_re),
    .raddr (rd_ptr_q),
    .rdata (ram_rdata)
  );

  assign dout         = dout_q;
  assign dout_valid   = dvld_q;
  assign full         = full_q;
  assign empty        = empty_q;
  assign almost_full  = af_q;
  assign almost_empty = ae_q;
  assign data_count   = count_q;
  assign overflow     = ovf_q;
  assign underflow    = unf_q;

endmodule

// File: tb/tb_sync_fifo_v2.sv
// Directed bench for sync_fifo_v2 at DATA_W=8, DEPTH=6, AF_LEVEL=4, AE_LEVEL=1.
module tb_sync_fifo_v2;

  logic       clk = 1'b0;
  logic       rst_n, clr, wr_en, rd_en;
  logic [7:0] din, dout;
  logic       dout_valid, full, empty, almost_full, almost_empty, overflow, underflow;
  logic [2:0] data_count;
  int         n_cmp = 0;
  int         n_err = 0;

  sync_fifo_v2 #(
    .DATA_W   (8),
    .DEPTH    (6),
    .AF_LEVEL (4),
    .AE_LEVEL (1)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .clr          (clr),
    .wr_en        (wr_en),
    .din          (din),
    .rd_en        (rd_en),
    .dout         (dout),
    .dout_valid   (dout_valid),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .data_count   (data_count),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0; clr = 1'b0; wr_en = 1'b0; rd_en = 1'b0; din = 8'h00;
    tick();
    tick();
    rst_n = 1'b1;
    chk("rst_dout", 32'(dout), 0);
    chk("rst_dvld", 32'(dout_valid), 0);
    chk("rst_count", 32'(data_count), 0);
    chk("rst_full", 32'(full), 0);
    chk("rst_empty", 32'(empty), 1);
    chk("rst_ae", 32'(almost_empty), 1);
    chk("rst_af", 32'(almost_full), 0);
    chk("rst_ovf", 32'(overflow), 0);
    chk("rst_unf", 32'(underflow), 0);

`ifndef SYNC_FIFO_FWFT_EN
    // Fill to full, checking every flag after each write.
    for (int i = 0; i < 6; i++) begin
      wr_en = 1'b1; din = 8'(8'h10 + i);
      tick();
      chk("fill_count", 32'(data_count), 32'(i + 1));
      chk("fill_ae", 32'(almost_empty), 32'((i + 1) <= 1));
      chk("fill_af", 32'(almost_full), 32'((i + 1) >= 4));
      chk("fill_full", 32'(full), 32'((i + 1) == 6));
      chk("fill_empty", 32'(empty), 0);
    end
    wr_en = 1'b1; din = 8'hAA;
    tick();
    wr_en = 1'b0;
    chk("ovf_flag", 32'(overflow), 1);
    chk("ovf_count", 32'(data_count), 6);
    chk("ovf_full", 32'(full), 1);

    // Drain: each read shows on dout one edge after it is accepted.
    for (int t = 0; t < 8; t++) begin
      rd_en = (t < 6);
      tick();
      if (t >= 1 && t <= 6) begin
        chk("drain_dout", 32'(dout), 32'(8'h10 + t - 1));
        chk("drain_dvld", 32'(dout_valid), 1);
      end
    end
    rd_en = 1'b0;
    chk("drain_dvld_end", 32'(dout_valid), 0);
    chk("drain_empty", 32'(empty), 1);
    chk("drain_count", 32'(data_count), 0);
    chk("drain_unf", 32'(underflow), 0);

    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("clr_ovf", 32'(overflow), 0);

    // Pointer wrap with simultaneous read/write at count 3.
    for (int i = 0; i < 3; i++) begin
      wr_en = 1'b1; din = 8'(8'h20 + i);
      tick();
    end
    for (int i = 0; i < 20; i++) begin
      wr_en = 1'b1; rd_en = 1'b1; din = 8'(8'h23 + i);
      tick();
      chk("wrap_count", 32'(data_count), 3);
      if (i >= 1) chk("wrap_dout", 32'(dout), 32'(8'h20 + i - 1));
    end
    wr_en = 1'b0; rd_en = 1'b0;
    tick();
    chk("wrap_last", 32'(dout), 32'h33);
    for (int t = 0; t < 4; t++) begin
      rd_en = (t < 3);
      tick();
      if (t >= 1) chk("wrap_drain", 32'(dout), 32'(8'h34 + t - 1));
    end
    rd_en = 1'b0;
    chk("wrap_count_end", 32'(data_count), 0);
    chk("wrap_empty", 32'(empty), 1);

    // Read from empty.
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    chk("unf_flag", 32'(underflow), 1);
    chk("unf_count", 32'(data_count), 0);
    chk("unf_dout", 32'(dout), 32'h36);
    chk("unf_dvld", 32'(dout_valid), 0);
    tick();
    chk("unf_dout_hold", 32'(dout), 32'h36);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("clr_unf", 32'(underflow), 0);
    chk("clr_dout", 32'(dout), 0);

    // Flush mid-operation: first via clr, then via rst_n, each with wr_en high.
    for (int pass = 0; pass < 2; pass++) begin
      for (int i = 0; i < 4; i++) begin
        wr_en = 1'b1; din = 8'(8'h40 + i);
        tick();
      end
      chk("flush_pre_count", 32'(data_count), 4);
      chk("flush_pre_af", 32'(almost_full), 1);
      wr_en = 1'b1; din = 8'h99;
      if (pass == 0) clr = 1'b1;
      else rst_n = 1'b0;
      tick();
      clr = 1'b0; rst_n = 1'b1; wr_en = 1'b0;
      chk("flush_count", 32'(data_count), 0);
      chk("flush_empty", 32'(empty), 1);
      chk("flush_full", 32'(full), 0);
      chk("flush_af", 32'(almost_full), 0);
      chk("flush_ae", 32'(almost_empty), 1);
      chk("flush_ovf", 32'(overflow), 0);
    end
`else
    // Single word falls through two clocks after the write edge.
    wr_en = 1'b1; din = 8'h5C;
    tick();
    wr_en = 1'b0;
    chk("fw_count", 32'(data_count), 1);
    chk("fw_dvld0", 32'(dout_valid), 0);
    tick();
    chk("fw_dvld1", 32'(dout_valid), 0);
    chk("fw_empty1", 32'(empty), 1);
    tick();
    chk("fw_dvld2", 32'(dout_valid), 1);
    chk("fw_dout2", 32'(dout), 32'h5C);
    chk("fw_empty2", 32'(empty), 0);
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    chk("fw_ack_dvld", 32'(dout_valid), 0);
    chk("fw_ack_empty", 32'(empty), 1);
    chk("fw_ack_count", 32'(data_count), 0);

    // Stream 10 words at one per clock, acknowledging each as it appears.
    for (int t = 0; t < 13; t++) begin
      wr_en = (t < 10); din = 8'(8'h60 + t);
      rd_en = (t >= 3);
      tick();
      if (t >= 2 && t <= 11) begin
        chk("fw_stream_dvld", 32'(dout_valid), 1);
        chk("fw_stream_dout", 32'(dout), 32'(8'h60 + t - 2));
      end
    end
    wr_en = 1'b0; rd_en = 1'b0;
    chk("fw_end_dvld", 32'(dout_valid), 0);
    chk("fw_end_empty", 32'(empty), 1);
    chk("fw_end_count", 32'(data_count), 0);
    chk("fw_end_unf", 32'(underflow), 0);
    chk("fw_end_ovf", 32'(overflow), 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
